// File: rtl/mix_char_tx_feeder_if.sv
// Word-in / char-out handshake bundle between the output-device
// controller, the MIX character feeder and the UART transmitter.
interface mix_char_tx_feeder_if;
  logic        word_valid;
  logic [29:0] word_in;
  logic        eol;
  logic        word_ready;
  logic        tx_load;
  logic [6:0]  tx_char;
  logic        tx_ready;
  logic        busy;

  modport slave (
    input  word_valid, word_in, eol, tx_ready,
    output word_ready, tx_load, tx_char, busy
  );

  modport master (
    output word_valid, word_in, eol, tx_ready,
    input  word_ready, tx_load, tx_char, busy
  );
endinterface

// File: rtl/mix_char_tx_feeder.sv
// Splits a MIX word into five characters, maps them to ASCII
// and feeds them to the UART, optionally followed by CR LF.
module mix_char_tx_feeder #(
  parameter bit         CRLF          = 1'b1,
  parameter logic [6:0] UNMAPPED_CHAR = 7'h3F
) (
  input logic                  clk,
  input logic                  rst_n,
  mix_char_tx_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CR,
    LF
  } state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [29:0] word_q;
  logic        eol_q;

  logic [5:0]  code;
  logic [6:0]  code7;
  logic [3:0]  pidx;
  logic [6:0]  punct;
  logic [6:0]  asc;
  logic        load;

  always_comb begin
    case (idx_q)
      3'd0:    code = word_q[29:24];
      3'd1:    code = word_q[23:18];
      3'd2:    code = word_q[17:12];
      3'd3:    code = word_q[11:6];
      default: code = word_q[5:0];
    endcase
  end

  assign code7 = {1'b0, code};
  // low nibble of (code - 40), since 40 mod 16 == 8
  assign pidx  = code[3:0] - 4'd8;

  always_comb begin
    case (pidx)
      4'd0:    punct = 7'h2E;
      4'd1:    punct = 7'h2C;
      4'd2:    punct = 7'h28;
      4'd3:    punct = 7'h29;
      4'd4:    punct = 7'h2B;
      4'd5:    punct = 7'h2D;
      4'd6:    punct = 7'h2A;
      4'd7:    punct = 7'h2F;
      4'd8:    punct = 7'h3D;
      4'd9:    punct = 7'h24;
      4'd10:   punct = 7'h3C;
      4'd11:   punct = 7'h3E;
      4'd12:   punct = 7'h40;
      4'd13:   punct = 7'h3B;
      4'd14:   punct = 7'h3A;
      default: punct = 7'h27;
    endcase
  end

  always_comb begin
    asc = UNMAPPED_CHAR;
    unique case (1'b1)
      code == 6'd0:
        asc = 7'h20;
      code inside {[6'd1:6'd9]}:
        asc = code7 + 7'h40;
      code == 6'd10:
        asc = 7'h7E;
      code inside {[6'd11:6'd19]}:
        asc = code7 + 7'h3F;
      code == 6'd20:
        asc = 7'h5B;
      code == 6'd21:
        asc = 7'h5D;
      code inside {[6'd22:6'd29]}:
        asc = code7 + 7'h3D;
      code inside {[6'd30:6'd39]}:
        asc = code7 + 7'h12;
      code inside {[6'd40:6'd55]}:
        asc = punct;
      default:
        asc = UNMAPPED_CHAR;
    endcase
  end

  assign load = (state_q != IDLE) && bus.tx_ready;

  assign bus.tx_load    = load;
  assign bus.word_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_char    = (state_q == CR) ? 7'h0D :
                          (state_q == LF) ? 7'h0A : asc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      word_q  <= '0;
      eol_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.word_valid) begin
            word_q  <= bus.word_in;
            eol_q   <= bus.eol;
            idx_q   <= 3'd0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (load) begin
            if (idx_q == 3'd4) begin
              idx_q   <= 3'd0;
              state_q <= (eol_q && CRLF) ? CR : IDLE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        CR: begin
          if (load) state_q <= LF;
        end
        LF: begin
          if (load) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_char_tx_feeder.sv
// Randomized bench for mix_char_tx_feeder against a queue-based
// model of the expected character stream.
module tb_mix_char_tx_feeder;

  logic clk;
  logic rst_n;
  mix_char_tx_feeder_if bus();

  mix_char_tx_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nloads = 0;
  int mode = 0;
  int cool = 0;
  bit loaded = 0;
  bit in_rst = 1;
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  int load_cyc[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_map(input logic [5:0] c);
    string s;
    byte b;
    s = " ABCDEFGHI~JKLMNOPQR[]STUVWXYZ0123456789.,()+-*/=$<>@;:'";
    if (c >= 6'd56) return 7'h3F;
    b = s[c];
    return b[6:0];
  endfunction

  function automatic logic [29:0] mk(input int a, input int b,
                                     input int c, input int d,
                                     input int e);
    logic [5:0] x0, x1, x2, x3, x4;
    x0 = a[5:0]; x1 = b[5:0]; x2 = c[5:0];
    x3 = d[5:0]; x4 = e[5:0];
    return {x0, x1, x2, x3, x4};
  endfunction

  // UART model: 0 pulsed, 1 always ready, 2 never ready
  always begin
    @(posedge clk);
    #1;
    case (mode)
      1: bus.tx_ready = 1'b1;
      2: bus.tx_ready = 1'b0;
      default: begin
        if (loaded) begin
          bus.tx_ready = 1'b0;
          cool = $urandom_range(1, 6);
        end else if (cool > 0) begin
          cool--;
          if (cool == 0) bus.tx_ready = 1'b1;
        end else begin
          bus.tx_ready = 1'b1;
        end
      end
    endcase
    loaded = 0;
  end

  always @(negedge clk) begin
    logic [6:0] e;
    cyc++;
    if (!in_rst) begin
      chk("busy", bus.busy, exp_q.size() != 0);
      chk("wrdy", bus.word_ready, exp_q.size() == 0);
      chk("load", bus.tx_load,
          bus.tx_ready && (exp_q.size() != 0));
      if (bus.tx_load && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("char", bus.tx_char, e);
        obs_q.push_back(bus.tx_char);
        load_cyc.push_back(cyc);
        nloads++;
        loaded = 1;
      end
    end
  end

  task automatic send_word(input logic [29:0] w, input logic e);
    int n;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b1;
    bus.word_in = w;
    bus.eol = e;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.word_ready) break;
      n++;
      if (n > 20000) begin
        chk("accept_timeout", 0, 1);
        bus.word_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 5; i++)
      exp_q.push_back(ref_map(w[29-6*i -: 6]));
    if (e) begin
      exp_q.push_back(7'h0D);
      exp_q.push_back(7'h0A);
    end
    #1;
    bus.word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        chk("drain_timeout", 0, 1);
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] hello[5];
    int base;
    int n;
    hello[0] = 7'h48; hello[1] = 7'h45;
    hello[2] = 7'h4C; hello[3] = 7'h4C;
    hello[4] = 7'h4F;
    rst_n = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in = '0;
    bus.eol = 1'b0;
    bus.tx_ready = 1'b1;
    #12;
    chk("rst_wrdy", bus.word_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_load", bus.tx_load, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 0;

    // HELLO without and with line terminator
    base = obs_q.size();
    send_word(mk(8, 5, 13, 13, 16), 1'b0);
    wait_idle();
    chk("hello_cnt", obs_q.size() - base, 5);
    for (int i = 0; i < 5; i++)
      chk("hello_kat", obs_q[base+i], hello[i]);

    base = obs_q.size();
    send_word(mk(8, 5, 13, 13, 16), 1'b1);
    wait_idle();
    chk("crlf_cnt", obs_q.size() - base, 7);
    chk("cr_kat", obs_q[base+5], 7'h0D);
    chk("lf_kat", obs_q[base+6], 7'h0A);

    send_word(mk(0, 10, 20, 21, 63), 1'b0);
    send_word(mk(30, 39, 40, 47, 55), 1'b0);
    wait_idle();

    // tx_ready stuck low freezes the feeder
    mode = 2;
    repeat (2) @(posedge clk);
    send_word(mk(1, 2, 3, 4, 5), 1'b1);
    repeat (20) @(negedge clk);
    chk("frozen", exp_q.size(), 7);
    mode = 0;
    wait_idle();

    // continuous ready: back-to-back words
    mode = 1;
    base = load_cyc.size();
    send_word(mk(11, 12, 22, 29, 56), 1'b0);
    send_word(mk(41, 42, 43, 44, 45), 1'b0);
    wait_idle();
    chk("consec", load_cyc[base+4] - load_cyc[base], 4);
    chk("gap", load_cyc[base+5] - load_cyc[base+4], 2);
    mode = 0;
    repeat (3) @(posedge clk);

    // reset after the second character of a word
    base = nloads;
    send_word(mk(17, 18, 19, 20, 21), 1'b1);
    n = 0;
    while (nloads < base + 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", nloads, base + 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_rst = 1;
    #1;
    chk("arst_load", bus.tx_load, 0);
    chk("arst_wrdy", bus.word_ready, 1);
    chk("arst_busy", bus.busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 0;
    repeat (12) @(negedge clk);
    chk("no_resume", nloads, base + 2);
    base = obs_q.size();
    send_word(mk(17, 18, 19, 20, 21), 1'b0);
    wait_idle();
    chk("restart_b1", obs_q[base], ref_map(6'd17));

    // random words, random eol and UART pacing
    for (int k = 0; k < 40; k++) begin
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_word(30'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
